// File: rtl/pipe_maindec.sv
// pipe_maindec: registered main decoder for the 5-stage MIPS core.
// Decodes instrD, drives D-stage branch/jump controls combinationally,
// and holds the control bundle in an E-stage register. MULT/DIV ops are
// kept in E for MUL_LAT/DIV_LAT cycles via an occupancy counter.
// Ports:
//   clk, rst         clock, async active-high reset
//   instrD, validD   D-stage instruction and its valid flag
//   stallE, flushE   hazard-unit hold / bubble requests for E
//   branchD, jumpD, jrD   combinational D-stage flow controls
//   validE .. riE    registered E-stage control bundle
//   mdu_stall        MDU op still occupying E
module pipe_maindec #(
   parameter int MUL_LAT = 1,
   parameter int DIV_LAT = 36,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrD,
   input  logic        validD,
   input  logic        stallE,
   input  logic        flushE,
   output logic        branchD,
   output logic        jumpD,
   output logic        jrD,
   output logic        validE,
   output logic        regwriteE,
   output logic        regdstE,
   output logic        alusrcE,
   output logic        memwriteE,
   output logic        memreadE,
   output logic [1:0]  mem_sizeE,
   output logic        mem_unsE,
   output logic [1:0]  wb_selE,
   output logic [1:0]  hilo_weE,
   output logic        hilo_srcE,
   output logic [1:0]  mdu_opE,
   output logic        signedE,
   output logic        linkE,
   output logic        jalE,
   output logic        riE,
   output logic        mdu_stall
);

   typedef struct packed {
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       memwrite;
      logic       memread;
      logic [1:0] mem_size;
      logic       mem_uns;
      logic [1:0] wb_sel;
      logic [1:0] hilo_we;
      logic       hilo_src;
      logic [1:0] mdu_op;
      logic       sgn;
      logic       link;
      logic       jal;
      logic       ri;
   } ctl_t;

   localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

   logic [5:0] op;
   logic [4:0] rt;
   logic [5:0] funct;
   logic [1:0] sz;

   logic is_special;
   logic is_regimm;
   logic is_j;
   logic is_jal;
   logic is_br;
   logic is_imm;
   logic is_load;
   logic is_store;

   ctl_t dc;
   logic br;
   logic jp;
   logic jr;

   ctl_t             e;
   logic             ve;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat_m1;

   assign op    = instrD[31:26];
   assign rt    = instrD[20:16];
   assign funct = instrD[5:0];

   // op[1:0] = 11 encodes a word access; remap to the 10 size code
   assign sz = (op[1:0] == 2'b11) ? 2'b10 : op[1:0];

   assign is_special = (op == 6'b000000);
   assign is_regimm  = (op == 6'b000001);
   assign is_j       = (op == 6'b000010);
   assign is_jal     = (op == 6'b000011);
   assign is_br      = (op[5:2] == 4'b0001);
   assign is_imm     = (op[5:3] == 3'b001);
   assign is_load    = (op == 6'b100000) || (op == 6'b100001) ||
                       (op == 6'b100011) || (op == 6'b100100) ||
                       (op == 6'b100101);
   assign is_store   = (op == 6'b101000) || (op == 6'b101001) ||
                       (op == 6'b101011);

   always_comb begin
      dc = '0;
      br = 1'b0;
      jp = 1'b0;
      jr = 1'b0;
      unique case (1'b1)
         is_special: begin
            case (funct)
               6'b001000: begin
                  jp = 1'b1;
                  jr = 1'b1;
               end
               6'b001001: begin
                  jp          = 1'b1;
                  jr          = 1'b1;
                  dc.link     = 1'b1;
                  dc.regwrite = 1'b1;
                  dc.regdst   = 1'b1;
               end
               6'b010000: begin
                  dc.regwrite = 1'b1;
                  dc.regdst   = 1'b1;
                  dc.wb_sel   = 2'b10;
               end
               6'b010010: begin
                  dc.regwrite = 1'b1;
                  dc.regdst   = 1'b1;
                  dc.wb_sel   = 2'b11;
               end
               6'b010001: begin
                  dc.hilo_we  = 2'b10;
                  dc.hilo_src = 1'b1;
               end
               6'b010011: begin
                  dc.hilo_we  = 2'b01;
                  dc.hilo_src = 1'b1;
               end
               6'b011000, 6'b011001: begin
                  dc.hilo_we = 2'b11;
                  dc.mdu_op  = 2'b01;
               end
               6'b011010, 6'b011011: begin
                  dc.hilo_we = 2'b11;
                  dc.mdu_op  = 2'b10;
               end
               default: begin
                  dc.regwrite = 1'b1;
                  dc.regdst   = 1'b1;
               end
            endcase
            // MULT and DIV are the signed forms; funct[0] marks unsigned
            dc.sgn = (funct[5:1] == 5'b01100) ||
                     (funct[5:1] == 5'b01101);
            dc.sgn = dc.sgn && !funct[0];
         end
         is_regimm: begin
            case (rt)
               5'b00000, 5'b00001: br = 1'b1;
               5'b10000, 5'b10001: begin
                  br          = 1'b1;
                  dc.link     = 1'b1;
                  dc.jal      = 1'b1;
                  dc.regwrite = 1'b1;
               end
               default: dc.ri = 1'b1;
            endcase
         end
         is_j: jp = 1'b1;
         is_jal: begin
            jp          = 1'b1;
            dc.link     = 1'b1;
            dc.jal      = 1'b1;
            dc.regwrite = 1'b1;
         end
         is_br: br = 1'b1;
         is_imm: begin
            dc.regwrite = 1'b1;
            dc.alusrc   = 1'b1;
            dc.sgn      = (op == 6'b001000);
         end
         is_load: begin
            dc.regwrite = 1'b1;
            dc.alusrc   = 1'b1;
            dc.memread  = 1'b1;
            dc.wb_sel   = 2'b01;
            dc.mem_size = sz;
            dc.mem_uns  = op[2];
         end
         is_store: begin
            dc.alusrc   = 1'b1;
            dc.memwrite = 1'b1;
            dc.mem_size = sz;
         end
         default: dc.ri = 1'b1;
      endcase
      if (!validD) begin
         dc = '0;
         br = 1'b0;
         jp = 1'b0;
         jr = 1'b0;
      end
   end

   assign branchD = br;
   assign jumpD   = jp;
   assign jrD     = jr;

   always_comb begin
      case (e.mdu_op)
         2'b01:   lat_m1 = MUL_M1;
         2'b10:   lat_m1 = DIV_M1;
         default: lat_m1 = '0;
      endcase
      mdu_stall = ve && (e.mdu_op != 2'b00) && (cnt < lat_m1);
   end

   // MDU occupancy wins over flushE so an op in flight is never killed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e   <= '0;
         ve  <= 1'b0;
         cnt <= '0;
      end else if (mdu_stall) begin
         cnt <= cnt + 1'b1;
      end else if (stallE) begin
         cnt <= cnt;
      end else if (flushE) begin
         e   <= '0;
         ve  <= 1'b0;
         cnt <= '0;
      end else begin
         e   <= dc;
         ve  <= validD;
         cnt <= '0;
      end
   end

   assign validE    = ve;
   assign regwriteE = e.regwrite;
   assign regdstE   = e.regdst;
   assign alusrcE   = e.alusrc;
   assign memwriteE = e.memwrite;
   assign memreadE  = e.memread;
   assign mem_sizeE = e.mem_size;
   assign mem_unsE  = e.mem_uns;
   assign wb_selE   = e.wb_sel;
   assign hilo_weE  = e.hilo_we;
   assign hilo_srcE = e.hilo_src;
   assign mdu_opE   = e.mdu_op;
   assign signedE   = e.sgn;
   assign linkE     = e.link;
   assign jalE      = e.jal;
   assign riE       = e.ri;

endmodule

// File: tb/tb_pipe_maindec.sv
// tb_pipe_maindec: table vectors, directed MDU/stall/reset sequences and
// random stimulus against a mnemonic-level reference model.
module tb_pipe_maindec;

   localparam int MUL_LAT = 1;
   localparam int DIV_LAT = 36;

   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       memwrite;
      logic       memread;
      logic [1:0] mem_size;
      logic       mem_uns;
      logic [1:0] wb_sel;
      logic [1:0] hilo_we;
      logic       hilo_src;
      logic [1:0] mdu_op;
      logic       sgn;
      logic       link;
      logic       jal;
      logic       ri;
   } ebun_t;

   typedef struct {
      logic [31:0] instr;
      logic        vd;
      logic [2:0]  bjr;
      ebun_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instrD;
   logic        validD, stallE, flushE;
   logic        branchD, jumpD, jrD;
   logic        validE, regwriteE, regdstE, alusrcE;
   logic        memwriteE, memreadE, mem_unsE, hilo_srcE;
   logic [1:0]  mem_sizeE, wb_selE, hilo_weE, mdu_opE;
   logic        signedE, linkE, jalE, riE, mdu_stall;

   int checks = 0;
   int failures = 0;

   ebun_t m_e;
   int    m_busy;
   ebun_t act;

   vec_t tbl[25];

   localparam ebun_t ADDI_E = 20'b110100_00_0_00_00_0_00_1000;

   always #5 clk = ~clk;

   pipe_maindec #(
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT),
      .CNT_W(6)
   ) dut (
      .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
      .stallE(stallE), .flushE(flushE),
      .branchD(branchD), .jumpD(jumpD), .jrD(jrD),
      .validE(validE), .regwriteE(regwriteE), .regdstE(regdstE),
      .alusrcE(alusrcE), .memwriteE(memwriteE), .memreadE(memreadE),
      .mem_sizeE(mem_sizeE), .mem_unsE(mem_unsE), .wb_selE(wb_selE),
      .hilo_weE(hilo_weE), .hilo_srcE(hilo_srcE), .mdu_opE(mdu_opE),
      .signedE(signedE), .linkE(linkE), .jalE(jalE), .riE(riE),
      .mdu_stall(mdu_stall)
   );

   assign act = {validE, regwriteE, regdstE, alusrcE, memwriteE,
                 memreadE, mem_sizeE, mem_unsE, wb_selE, hilo_weE,
                 hilo_srcE, mdu_opE, signedE, linkE, jalE, riE};

   task automatic chk(string name, logic [31:0] a, logic [31:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, a, x);
      end
   endtask

   // mnemonic-level reference decode; bjr = {branch, jump, jr}
   function automatic ebun_t ref_dec(input logic [31:0] i,
                                     input logic vd,
                                     output logic [2:0] bjr);
      ebun_t r;
      int op, fn, rt;
      op  = int'(i[31:26]);
      fn  = int'(i[5:0]);
      rt  = int'(i[20:16]);
      r   = '0;
      bjr = 3'b000;
      if (!vd) return r;
      r.valid = 1'b1;
      if (op == 0) begin
         if (fn == 8) bjr = 3'b011;
         else if (fn == 9) begin
            bjr = 3'b011; r.link = 1; r.regwrite = 1; r.regdst = 1;
         end else if (fn == 16 || fn == 18) begin
            r.regwrite = 1; r.regdst = 1;
            r.wb_sel = (fn == 16) ? 2'b10 : 2'b11;
         end else if (fn == 17 || fn == 19) begin
            r.hilo_src = 1;
            r.hilo_we = (fn == 17) ? 2'b10 : 2'b01;
         end else if (fn >= 24 && fn <= 27) begin
            r.hilo_we = 2'b11;
            r.mdu_op = (fn <= 25) ? 2'd1 : 2'd2;
            r.sgn = (fn == 24 || fn == 26);
         end else begin
            r.regwrite = 1; r.regdst = 1;
         end
      end else if (op == 1) begin
         if (rt == 0 || rt == 1) bjr = 3'b100;
         else if (rt == 16 || rt == 17) begin
            bjr = 3'b100; r.link = 1; r.jal = 1; r.regwrite = 1;
         end else r.ri = 1;
      end else if (op == 2) bjr = 3'b010;
      else if (op == 3) begin
         bjr = 3'b010; r.link = 1; r.jal = 1; r.regwrite = 1;
      end else if (op >= 4 && op <= 7) bjr = 3'b100;
      else if (op >= 8 && op <= 15) begin
         r.regwrite = 1; r.alusrc = 1; r.sgn = (op == 8);
      end else if (op == 32 || op == 33 || op == 35 ||
                   op == 36 || op == 37) begin
         r.regwrite = 1; r.alusrc = 1; r.memread = 1; r.wb_sel = 2'b01;
         r.mem_size = (op == 35) ? 2'd2 :
                      (op == 33 || op == 37) ? 2'd1 : 2'd0;
         r.mem_uns = (op >= 36);
      end else if (op == 40 || op == 41 || op == 43) begin
         r.alusrc = 1; r.memwrite = 1;
         r.mem_size = (op == 43) ? 2'd2 : (op == 41) ? 2'd1 : 2'd0;
      end else r.ri = 1;
      return r;
   endfunction

   function automatic int lat_of(logic [1:0] m);
      return (m == 2'd1) ? MUL_LAT : (m == 2'd2) ? DIV_LAT : 1;
   endfunction

   // advance model and DUT one clock, checking D comb, E and stall
   task automatic tick(string tag);
      ebun_t d;
      logic [2:0] bjr;
      #1;
      d = ref_dec(instrD, validD, bjr);
      chk({tag, ":d"}, 32'({branchD, jumpD, jrD}), 32'(bjr));
      if (m_busy > 0) m_busy--;
      else if (stallE) m_busy = 0;
      else if (flushE) m_e = '0;
      else begin
         m_e = d;
         m_busy = lat_of(d.mdu_op) - 1;
      end
      @(posedge clk);
      #1;
      chk({tag, ":e"}, 32'(act), 32'(m_e));
      chk({tag, ":stall"}, 32'(mdu_stall), 32'(m_busy > 0));
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      logic [5:0] fl[8] = '{6'h08, 6'h09, 6'h10, 6'h11,
                            6'h12, 6'h13, 6'h18, 6'h19};
      logic [5:0] ld[8] = '{6'h20, 6'h21, 6'h23, 6'h24,
                            6'h25, 6'h28, 6'h29, 6'h2b};
      r = $urandom;
      case ($urandom_range(0, 39))
         0, 1, 2, 3: r[31:26] = 6'd0;
         4, 5, 6, 7, 8: begin
            r[31:26] = 6'd0;
            r[5:0] = fl[$urandom_range(0, 7)];
         end
         9, 10, 11: begin
            r[31:26] = 6'd1;
            if ($urandom_range(0, 1) == 1) r[19:17] = 3'b000;
         end
         12, 13, 14, 15: r[31:26] = 6'($urandom_range(2, 7));
         16, 17, 18, 19: r[31:26] = 6'($urandom_range(8, 15));
         20, 21, 22, 23, 24, 25: r[31:26] = ld[$urandom_range(0, 7)];
         26: begin
            r[31:26] = 6'd0;
            r[5:0] = ($urandom_range(0, 1) == 1) ? 6'h1a : 6'h1b;
         end
         default: r = r;
      endcase
      return r;
   endfunction

   initial begin
      int n;
      tbl[0]  = '{32'h8C880004, 1, 3'b000, 20'b110101_10_0_01_00_0_00_0000};
      tbl[1]  = '{32'h90880000, 1, 3'b000, 20'b110101_00_1_01_00_0_00_0000};
      tbl[2]  = '{32'h84880000, 1, 3'b000, 20'b110101_01_0_01_00_0_00_0000};
      tbl[3]  = '{32'hA0880000, 1, 3'b000, 20'b100110_00_0_00_00_0_00_0000};
      tbl[4]  = '{32'hAC880000, 1, 3'b000, 20'b100110_10_0_00_00_0_00_0000};
      tbl[5]  = '{32'h20880005, 1, 3'b000, 20'b110100_00_0_00_00_0_00_1000};
      tbl[6]  = '{32'h34880005, 1, 3'b000, 20'b110100_00_0_00_00_0_00_0000};
      tbl[7]  = '{32'h01095020, 1, 3'b000, 20'b111000_00_0_00_00_0_00_0000};
      tbl[8]  = '{32'h00005010, 1, 3'b000, 20'b111000_00_0_10_00_0_00_0000};
      tbl[9]  = '{32'h00005012, 1, 3'b000, 20'b111000_00_0_11_00_0_00_0000};
      tbl[10] = '{32'h01000011, 1, 3'b000, 20'b100000_00_0_00_10_1_00_0000};
      tbl[11] = '{32'h01000013, 1, 3'b000, 20'b100000_00_0_00_01_1_00_0000};
      tbl[12] = '{32'h01090018, 1, 3'b000, 20'b100000_00_0_00_11_0_01_1000};
      tbl[13] = '{32'h01090019, 1, 3'b000, 20'b100000_00_0_00_11_0_01_0000};
      tbl[14] = '{32'h01000008, 1, 3'b011, 20'b100000_00_0_00_00_0_00_0000};
      tbl[15] = '{32'h0100F809, 1, 3'b011, 20'b111000_00_0_00_00_0_00_0100};
      tbl[16] = '{32'h08000010, 1, 3'b010, 20'b100000_00_0_00_00_0_00_0000};
      tbl[17] = '{32'h0C000010, 1, 3'b010, 20'b110000_00_0_00_00_0_00_0110};
      tbl[18] = '{32'h11090004, 1, 3'b100, 20'b100000_00_0_00_00_0_00_0000};
      tbl[19] = '{32'h04110002, 1, 3'b100, 20'b110000_00_0_00_00_0_00_0110};
      tbl[20] = '{32'h04000003, 1, 3'b100, 20'b100000_00_0_00_00_0_00_0000};
      tbl[21] = '{32'h04150003, 1, 3'b000, 20'b100000_00_0_00_00_0_00_0001};
      tbl[22] = '{32'hFC000000, 1, 3'b000, 20'b100000_00_0_00_00_0_00_0001};
      tbl[23] = '{32'h8C880004, 0, 3'b000, 20'b000000_00_0_00_00_0_00_0000};
      tbl[24] = '{32'h88880000, 1, 3'b000, 20'b100000_00_0_00_00_0_00_0001};

      rst = 1'b1;
      instrD = 32'h0;
      validD = 1'b0;
      stallE = 1'b0;
      flushE = 1'b0;
      m_e = '0;
      m_busy = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_e", 32'(act), 32'h0);
      chk("reset_stall", 32'(mdu_stall), 32'h0);
      rst = 1'b0;

      foreach (tbl[k]) begin
         instrD = tbl[k].instr;
         validD = tbl[k].vd;
         #1;
         chk($sformatf("tbl%0d_d", k), 32'({branchD, jumpD, jrD}),
             32'(tbl[k].bjr));
         tick($sformatf("tbl%0d", k));
         chk($sformatf("tbl%0d_e", k), 32'(act), 32'(tbl[k].exp));
         chk($sformatf("tbl%0d_nostall", k), 32'(mdu_stall), 32'h0);
      end

      // DIV occupancy with an ignored flush mid-flight
      instrD = 32'h0109001A;
      validD = 1'b1;
      tick("div_ld");
      chk("div_stall_on", 32'(mdu_stall), 32'h1);
      instrD = 32'h20880005;
      n = 0;
      while (mdu_stall && n < 100) begin
         flushE = (n == 10);
         tick("div_hold");
         n++;
      end
      flushE = 1'b0;
      chk("div_len", 32'(n), 32'd35);
      chk("div_in_e", 32'({validE, mdu_opE}), 32'b110);
      tick("div_next");
      chk("after_div", 32'(act), 32'(ADDI_E));

      // stall beats flush; then plain flush bubbles
      instrD = 32'h8C880004;
      stallE = 1'b1;
      flushE = 1'b1;
      tick("stall_flush");
      chk("stall_flush_hold", 32'(act), 32'(ADDI_E));
      stallE = 1'b0;
      tick("flush");
      chk("flush_bubble", 32'(act), 32'h0);
      flushE = 1'b0;

      // MULT with unit latency never stalls
      instrD = 32'h01090018;
      tick("mult");
      chk("mult_nostall", 32'(mdu_stall), 32'h0);
      chk("mult_op", 32'(mdu_opE), 32'h1);

      // async reset in the middle of a DIV
      instrD = 32'h0109001A;
      tick("div2_ld");
      instrD = 32'h20880005;
      repeat (5) tick("div2_hold");
      chk("div2_mid", 32'(mdu_stall), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_mid_e", 32'(act), 32'h0);
      chk("rst_mid_stall", 32'(mdu_stall), 32'h0);
      m_e = '0;
      m_busy = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int c = 0; c < 2000; c++) begin
         instrD = rnd_instr();
         validD = ($urandom_range(0, 7) != 0);
         stallE = ($urandom_range(0, 6) == 0);
         flushE = ($urandom_range(0, 6) == 0);
         tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
